// File: rtl/spi_transaction_manager.sv
// spi_transaction_manager
//   Command sequencer in front of SPI_Engine. Takes one 32-bit command word
//   on a valid/ready request port, presents it to the engine, waits for
//   EngineDone (or a timeout), and returns the captured 16-bit MISO word on a
//   valid/ready response port. After reset or a timeout the engine is given a
//   flush window to finish any in-flight frame before a new request is taken.
//
// Ports
//   clk_for_SPI, nReset       clock, async active-low reset
//   Req_Valid/Ready/Data      request handshake, 32-bit command word
//   Resp_Valid/Ready          response handshake
//   Resp_Data, Resp_Error     captured MISO data; error = timed out (data 0)
//   Tx_Data, EngineStart      to engine
//   EngineDone, Rx_Data       from engine
//   Busy                      high in every state except IDLE
//   Txn_Count                 completed good transactions, wraps
//   Timeout_Count             timeouts, saturates at 255
//
// state   | meaning
// FLUSH   | Req_Ready low; wait FLUSH_CYCLES and EngineDone low
// IDLE    | Req_Ready high; accept next command word
// SETUP   | Tx_Data settles before EngineStart rises
// START   | EngineStart high; wait EngineDone or timeout
// RELEASE | wait EngineDone low, then GAP_CYCLES of NCS-high time
// RESP    | Resp_Valid high until Resp_Ready

module spi_transaction_manager #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FLUSH_CYCLES   = 40,
    parameter int GAP_CYCLES     = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk_for_SPI,
    input  logic                 nReset,
    input  logic                 Req_Valid,
    output logic                 Req_Ready,
    input  logic [31:0]          Req_Data,
    output logic                 Resp_Valid,
    input  logic                 Resp_Ready,
    output logic [15:0]          Resp_Data,
    output logic                 Resp_Error,
    output logic [31:0]          Tx_Data,
    output logic                 EngineStart,
    input  logic                 EngineDone,
    input  logic [15:0]          Rx_Data,
    output logic                 Busy,
    output logic [CNT_WIDTH-1:0] Txn_Count,
    output logic [7:0]           Timeout_Count
);

    // One shared up-counting timer serves all three waits.
    localparam int TMAX_FT = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
    localparam int TMAX    = (TMAX_FT > GAP_CYCLES) ? TMAX_FT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMAX + 1);

    localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FLUSH, S_IDLE, S_SETUP, S_START, S_RELEASE, S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [31:0]            tx_q, tx_d;
    logic                   start_q, start_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   rerr_q, rerr_d;
    logic [CNT_WIDTH-1:0]   txn_q, txn_d;
    logic [7:0]             tmo_q, tmo_d;

    always_ff @(posedge clk_for_SPI or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_FLUSH;
            timer_q <= '0;
            tx_q    <= '0;
            start_q <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            txn_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            txn_q   <= txn_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tx_d    = tx_q;
        start_d = start_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        txn_d   = txn_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_FLUSH: begin
                // Timer parks at its last value while the engine still reports done.
                if (timer_q == FLUSH_LAST) begin
                    if (!EngineDone) state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (Req_Valid) begin
                    tx_d    = Req_Data;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                start_d = 1'b1;
                timer_d = '0;
                state_d = S_START;
            end
            S_START: begin
                // Done takes priority over a timeout on the same cycle.
                if (EngineDone) begin
                    rdata_d = Rx_Data;
                    rerr_d  = 1'b0;
                    start_d = 1'b0;
                    txn_d   = txn_q + 1'b1;
                    timer_d = '0;
                    state_d = S_RELEASE;
                end else if (timer_q == TMO_LAST) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    start_d = 1'b0;
                    if (tmo_q != 8'hFF) tmo_d = tmo_q + 1'b1;
                    timer_d = '0;
                    state_d = S_RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RELEASE: begin
                // Gap count restarts while EngineDone is still high.
                if (EngineDone) begin
                    timer_d = '0;
                end else if (GAP_CYCLES == 0 || timer_q == GAP_LAST) begin
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                if (Resp_Ready) begin
                    timer_d = '0;
                    state_d = rerr_q ? S_FLUSH : S_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_FLUSH;
            end
        endcase
    end

    assign Req_Ready     = (state_q == S_IDLE);
    assign Resp_Valid    = (state_q == S_RESP);
    assign Busy          = (state_q != S_IDLE);
    assign Tx_Data       = tx_q;
    assign EngineStart   = start_q;
    assign Resp_Data     = rdata_q;
    assign Resp_Error    = rerr_q;
    assign Txn_Count     = txn_q;
    assign Timeout_Count = tmo_q;

endmodule

// File: tb/tb_spi_transaction_manager.sv
// tb_spi_transaction_manager
//   Drives spi_transaction_manager against a small behavioural SPI engine and
//   compares every response, counter and timing window with expectations kept
//   in the bench (expected response word, good/timeout tallies, cycle windows).

module tb_spi_transaction_manager;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int FLUSH_CYCLES   = 40;
    localparam int GAP_CYCLES     = 2;

    logic        clk_for_SPI = 1'b0;
    logic        nReset      = 1'b0;
    logic        Req_Valid   = 1'b0;
    logic [31:0] Req_Data    = '0;
    logic        Resp_Ready  = 1'b0;
    logic        EngineDone  = 1'b0;
    logic [15:0] Rx_Data     = '0;
    logic        Req_Ready, Resp_Valid, Resp_Error, EngineStart, Busy;
    logic [15:0] Resp_Data;
    logic [31:0] Tx_Data;
    logic [15:0] Txn_Count;
    logic [7:0]  Timeout_Count;

    always #5 clk_for_SPI = ~clk_for_SPI;

    spi_transaction_manager #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FLUSH_CYCLES  (FLUSH_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES),
        .CNT_WIDTH     (16)
    ) dut (
        .clk_for_SPI  (clk_for_SPI),
        .nReset       (nReset),
        .Req_Valid    (Req_Valid),
        .Req_Ready    (Req_Ready),
        .Req_Data     (Req_Data),
        .Resp_Valid   (Resp_Valid),
        .Resp_Ready   (Resp_Ready),
        .Resp_Data    (Resp_Data),
        .Resp_Error   (Resp_Error),
        .Tx_Data      (Tx_Data),
        .EngineStart  (EngineStart),
        .EngineDone   (EngineDone),
        .Rx_Data      (Rx_Data),
        .Busy         (Busy),
        .Txn_Count    (Txn_Count),
        .Timeout_Count(Timeout_Count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Engine model: after eng_lat cycles of EngineStart high it raises
    // EngineDone with eng_rx; mode 1 never finishes. Done drops once
    // EngineStart is low. eng_force pins Done high (stuck engine).
    int          eng_mode  = 0;
    int          eng_lat   = 33;
    logic [15:0] eng_rx    = '0;
    bit          eng_force = 1'b0;
    int          eng_cnt   = 0;
    int          low_run   = 0;
    int          min_gap   = 1000;
    bit          seen_start = 1'b0;
    logic        prev_start = 1'b0;

    always @(negedge clk_for_SPI) begin
        if (eng_force) begin
            EngineDone = 1'b1;
        end else if (!nReset || !EngineStart) begin
            EngineDone = 1'b0;
            eng_cnt    = 0;
        end else if (!EngineDone) begin
            eng_cnt++;
            if (eng_mode == 0 && eng_cnt >= eng_lat) EngineDone = 1'b1;
        end
        Rx_Data = EngineDone ? eng_rx : 16'($urandom);
        if (EngineStart && !prev_start) begin
            if (seen_start && low_run < min_gap) min_gap = low_run;
            seen_start = 1'b1;
            low_run    = 0;
        end
        if (!EngineDone) low_run++;
        else             low_run = 0;
        prev_start = EngineStart;
    end

    // Reference tallies.
    int m_txn = 0;
    int m_tmo = 0;

    task automatic wait_ready(output int n);
        n = 0;
        while (!Req_Ready && n < 300) begin
            @(negedge clk_for_SPI);
            n++;
        end
    endtask

    // One full transaction. mode 0 = engine answers after lat cycles with rx,
    // mode 1 = engine never answers. hold = cycles Resp_Ready stays low with a
    // competing request waiting.
    task automatic do_txn(input logic [31:0] d, input int mode, input int lat,
                          input logic [15:0] rx, input int hold);
        int          n, cyc, shi, exp_shi;
        logic [15:0] erd;
        logic        eerr;
        eng_mode  = mode;
        eng_lat   = lat;
        eng_rx    = rx;
        Req_Data  = d;
        Req_Valid = 1'b1;
        wait_ready(n);
        chk("accept_wait", n < 300, 1);
        @(negedge clk_for_SPI);
        Req_Valid = 1'b0;
        Req_Data  = $urandom;
        chk("tx_data", Tx_Data, d);
        chk("busy_after_accept", Busy, 1);

        if (mode == 0) begin
            m_txn++;
            erd = rx; eerr = 1'b0; exp_shi = lat;
        end else begin
            if (m_tmo < 255) m_tmo++;
            erd = 16'h0; eerr = 1'b1; exp_shi = TIMEOUT_CYCLES;
        end

        cyc = 0; shi = 0;
        while (!Resp_Valid && cyc < 150) begin
            @(negedge clk_for_SPI);
            cyc++;
            if (EngineStart) shi++;
        end
        chk("resp_valid", Resp_Valid, 1);
        chk("start_cycles", shi, exp_shi);
        chk("resp_data", Resp_Data, erd);
        chk("resp_error", Resp_Error, eerr);
        chk("txn_count", Txn_Count, m_txn & 32'hFFFF);
        chk("timeout_count", Timeout_Count, m_tmo);
        chk("tx_hold", Tx_Data, d);
        if (mode == 0) begin
            chk("resp_latency_max", cyc <= 40, 1);
            chk("resp_latency_gap", (cyc >= lat + 1 + GAP_CYCLES) && (cyc <= lat + 2 + GAP_CYCLES), 1);
        end

        for (int i = 0; i < hold; i++) begin
            Req_Valid = 1'b1;
            Req_Data  = $urandom;
            @(negedge clk_for_SPI);
            chk("hold_valid", Resp_Valid, 1);
            chk("hold_data", Resp_Data, erd);
            chk("hold_no_accept", Req_Ready, 0);
            chk("hold_no_start", EngineStart, 0);
            chk("hold_tx", Tx_Data, d);
        end
        Req_Valid  = 1'b0;
        Resp_Ready = 1'b1;
        @(negedge clk_for_SPI);
        Resp_Ready = 1'b0;
        chk("resp_taken", Resp_Valid, 0);
        chk("resp_data_kept", Resp_Data, erd);
        if (eerr) begin
            wait_ready(n);
            chk("post_timeout_flush", n, FLUSH_CYCLES);
        end
    endtask

    initial begin
        int   n;
        logic bad;

        // Reset values and flush window.
        repeat (3) @(negedge clk_for_SPI);
        chk("rst_req_ready", Req_Ready, 0);
        chk("rst_start", EngineStart, 0);
        chk("rst_resp_valid", Resp_Valid, 0);
        chk("rst_resp_data", Resp_Data, 0);
        chk("rst_resp_error", Resp_Error, 0);
        chk("rst_tx_data", Tx_Data, 0);
        chk("rst_txn", Txn_Count, 0);
        chk("rst_tmo", Timeout_Count, 0);
        chk("rst_busy", Busy, 1);
        nReset = 1'b1;
        n = 0; bad = 1'b0;
        while (!Req_Ready && n < 300) begin
            @(negedge clk_for_SPI);
            n++;
            if (!Req_Ready)
                bad |= EngineStart | Resp_Valid | (Tx_Data != 0) | !Busy | Resp_Error;
        end
        chk("flush_len_reset", n, FLUSH_CYCLES);
        chk("flush_outputs_quiet", bad, 0);
        chk("idle_not_busy", Busy, 0);

        // Directed good transaction.
        do_txn(32'hA5C3_0F12, 0, 33, 16'hBEEF, 0);

        // Engine never answers.
        do_txn(32'h1234_5678, 1, 0, 16'h0, 0);

        // Response back-pressure with a competing request.
        do_txn(32'hCAFE_F00D, 0, 31, 16'h5A5A, 20);

        // Reset ten cycles into START.
        eng_mode = 0; eng_lat = 33; eng_rx = 16'h1111;
        Req_Data = 32'hDEAD_BEEF; Req_Valid = 1'b1;
        wait_ready(n);
        @(negedge clk_for_SPI);
        Req_Valid = 1'b0;
        repeat (11) @(negedge clk_for_SPI);
        chk("mid_start_high", EngineStart, 1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_start_low", EngineStart, 0);
        chk("mid_rst_tx", Tx_Data, 0);
        chk("mid_rst_txn", Txn_Count, 0);
        m_txn = 0; m_tmo = 0;
        @(negedge clk_for_SPI);
        @(negedge clk_for_SPI);
        nReset = 1'b1;
        wait_ready(n);
        chk("flush_len_midrst", n, FLUSH_CYCLES);
        do_txn(32'h0BAD_CAFE, 0, 33, 16'h7E57, 0);

        // Stuck EngineDone keeps the flush open past its minimum length.
        @(negedge clk_for_SPI);
        nReset = 1'b0;
        eng_force = 1'b1;
        m_txn = 0; m_tmo = 0;
        @(negedge clk_for_SPI);
        nReset = 1'b1;
        repeat (50) @(negedge clk_for_SPI);
        chk("flush_hold_done", Req_Ready, 0);
        eng_force = 1'b0;
        wait_ready(n);
        chk("flush_release", (n >= 1) && (n <= 2), 1);

        // 300 back-to-back good transactions.
        for (int i = 0; i < 300; i++)
            do_txn($urandom, 0, $urandom_range(34, 28), 16'($urandom), $urandom_range(2, 0));
        chk("txn_300", Txn_Count, 300);
        chk("tmo_zero", Timeout_Count, 0);

        // Mixed traffic with occasional timeouts.
        for (int i = 0; i < 30; i++)
            do_txn($urandom, ($urandom_range(7, 0) == 0) ? 1 : 0,
                   $urandom_range(34, 28), 16'($urandom), $urandom_range(3, 0));

        chk("min_done_gap", min_gap >= GAP_CYCLES, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
